// File: rtl/load_extend_pkg.sv
// load_extend_pkg: shared types for the load-data formatter.
//   t_LoadSize  - access size encoding (byte/half/word/double)
//   t_SkidState - occupancy of the output/skid register pair
//   t_LoadBeat  - one held beat {Q, Tag, Fault}, sized for the widest build
//   lane_bytes  - number of bytes covered by an access size
package load_extend_pkg;

  localparam int LE_MAX_DATA_W = 64;
  localparam int LE_MAX_TAG_W  = 16;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'd0,
    SIZE_HALF   = 2'd1,
    SIZE_WORD   = 2'd2,
    SIZE_DOUBLE = 2'd3
  } t_LoadSize;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } t_SkidState;

  // Fields are sized for the widest legal configuration; narrower builds
  // use the low bits only.
  typedef struct packed {
    logic [LE_MAX_DATA_W-1:0] Q;
    logic [LE_MAX_TAG_W-1:0]  Tag;
    logic                     Fault;
  } t_LoadBeat;

  function automatic int lane_bytes(input t_LoadSize size);
    return 1 << int'(size);
  endfunction

endpackage

// File: rtl/load_format.sv
// load_format: combinational lane extract + zero/sign extension.
//   d           raw memory word
//   offset      byte offset of the lane within d
//   size        access size (t_LoadSize)
//   is_unsigned 1 = zero-extend, 0 = sign-extend
//   q           formatted result
//   fault       misaligned / illegal-size beat
// Build option LOAD_EXTEND_FAULT_EN: when defined, faulting beats raise
// fault and return q=0; otherwise the offset is aligned down and an
// illegal size is treated as a full-width word.
module load_format
  import load_extend_pkg::*;
#(
  parameter int p_DataWidth = 32
) (
  input  logic [p_DataWidth-1:0]          d,
  input  logic [$clog2(p_DataWidth/8)-1:0] offset,
  input  t_LoadSize                       size,
  input  logic                            is_unsigned,
  output logic [p_DataWidth-1:0]          q,
  output logic                            fault
);

  localparam int OffW = $clog2(p_DataWidth/8);

  int                   lane_req;
  int                   lane_eff;
  int                   lane_bits;
  logic                 illegal;
  logic                 misaligned;
  logic [OffW-1:0]      align_mask;
  logic [OffW-1:0]      offset_al;
  logic [p_DataWidth-1:0] shifted;
  logic [p_DataWidth-1:0] low_mask;
  logic [p_DataWidth-1:0] top_mask;
  logic                 sign_bit;
  logic [p_DataWidth-1:0] ext;

  always_comb begin
    lane_req = lane_bytes(size);
    illegal  = lane_req > p_DataWidth/8;
    // An oversize access collapses to the full word so the shift/mask
    // arithmetic below never runs past the datapath.
    lane_eff   = illegal ? p_DataWidth/8 : lane_req;
    lane_bits  = lane_eff * 8;
    align_mask = OffW'(lane_eff - 1);
    misaligned = |(offset & align_mask);
    offset_al  = offset & ~align_mask;
    shifted    = d >> {offset_al, 3'b000};
    low_mask   = (lane_bits >= p_DataWidth) ? '1
               : ((p_DataWidth'(1) << lane_bits) - p_DataWidth'(1));
    top_mask   = p_DataWidth'(1) << (lane_bits - 1);
    sign_bit   = |(shifted & top_mask);
    ext        = (shifted & low_mask)
               | (~low_mask & {p_DataWidth{sign_bit & ~is_unsigned}});
  end

`ifdef LOAD_EXTEND_FAULT_EN
  assign fault = illegal | misaligned;
  assign q     = fault ? '0 : ext;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign fault = 1'b0;
  assign q     = ext;
`endif

endmodule

// File: rtl/load_extend_pipe.sv
// load_extend_pipe: load-data formatter with a 2-entry valid/ready skid
// stage between the memory read port and register writeback.
//   i_CLK, i_RST        clock, synchronous active-high reset
//   i_Flush             discard every held beat (and one accepted now)
//   i_Valid / o_Ready   input handshake; o_Ready = skid slot free
//   i_D, i_Offset,
//   i_Size, i_Unsigned  raw word and lane selection / extension mode
//   i_Tag               pass-through destination tag
//   o_Valid / i_Ready   output handshake
//   o_Q, o_Tag, o_Fault formatted result of the head beat
// Build option LOAD_EXTEND_FAULT_EN enables fault reporting (see load_format).
module load_extend_pipe
  import load_extend_pkg::*;
#(
  parameter int p_DataWidth = 32,
  parameter int p_TagWidth  = 5
) (
  input  logic                            i_CLK,
  input  logic                            i_RST,
  input  logic                            i_Flush,
  input  logic                            i_Valid,
  output logic                            o_Ready,
  input  logic [p_DataWidth-1:0]          i_D,
  input  logic [$clog2(p_DataWidth/8)-1:0] i_Offset,
  input  logic [1:0]                      i_Size,
  input  logic                            i_Unsigned,
  input  logic [p_TagWidth-1:0]           i_Tag,
  output logic                            o_Valid,
  input  logic                            i_Ready,
  output logic [p_DataWidth-1:0]          o_Q,
  output logic [p_TagWidth-1:0]           o_Tag,
  output logic                            o_Fault
);

  logic [p_DataWidth-1:0] fmt_q;
  logic                   fmt_fault;

  load_format #(.p_DataWidth(p_DataWidth)) u_format (
    .d           (i_D),
    .offset      (i_Offset),
    .size        (t_LoadSize'(i_Size)),
    .is_unsigned (i_Unsigned),
    .q           (fmt_q),
    .fault       (fmt_fault)
  );

  t_LoadBeat  beat_in;
  t_LoadBeat  out_reg, out_next;
  t_LoadBeat  skid_reg, skid_next;
  logic       out_valid_reg, out_valid_next;
  logic       skid_valid_reg, skid_valid_next;
  t_SkidState state;
  logic       accept;
  logic       drain;

  // Ready depends only on held state (plus reset), never on i_Ready.
  assign o_Ready = ~skid_valid_reg | i_RST;
  assign accept  = i_Valid & o_Ready;
  assign drain   = out_valid_reg & i_Ready;

  always_comb begin
    beat_in       = '0;
    beat_in.Q     = LE_MAX_DATA_W'(fmt_q);
    beat_in.Tag   = LE_MAX_TAG_W'(i_Tag);
    beat_in.Fault = fmt_fault;
  end

  always_comb begin
    unique case ({skid_valid_reg, out_valid_reg})
      2'b00:   state = ST_EMPTY;
      2'b01:   state = ST_ONE;
      default: state = ST_FULL;
    endcase
  end

  always_comb begin
    out_next        = out_reg;
    skid_next       = skid_reg;
    out_valid_next  = out_valid_reg;
    skid_valid_next = skid_valid_reg;
    unique case (state)
      ST_EMPTY: begin
        if (accept) begin
          out_next       = beat_in;
          out_valid_next = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !drain) begin
          skid_next       = beat_in;
          skid_valid_next = 1'b1;
        end else if (accept && drain) begin
          out_next = beat_in;
        end else if (drain) begin
          out_valid_next = 1'b0;
        end
      end
      default: begin
        // Skid is full so nothing can be accepted; draining promotes it.
        if (drain) begin
          out_next        = skid_reg;
          skid_valid_next = 1'b0;
        end
      end
    endcase
    if (i_Flush) begin
      out_valid_next  = 1'b0;
      skid_valid_next = 1'b0;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      out_reg        <= '0;
      skid_reg       <= '0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      out_reg        <= out_next;
      skid_reg       <= skid_next;
      out_valid_reg  <= out_valid_next;
      skid_valid_reg <= skid_valid_next;
    end
  end

  assign o_Valid = out_valid_reg;
  assign o_Q     = out_reg.Q[p_DataWidth-1:0];
  assign o_Tag   = out_reg.Tag[p_TagWidth-1:0];
  assign o_Fault = out_reg.Fault;

  // Struct bits above the configured widths are never driven non-zero.
  logic unused_hi;
  assign unused_hi = ^{out_reg.Q >> p_DataWidth, out_reg.Tag >> p_TagWidth};

endmodule

// File: tb/tb_load_extend_pipe.sv
module tb_load_extend_pipe;

  logic        clk = 1'b0;
  logic        i_RST, i_Flush, i_Valid, i_Unsigned, i_Ready;
  logic [31:0] i_D;
  logic [1:0]  i_Offset, i_Size;
  logic [4:0]  i_Tag;
  logic        o_Ready, o_Valid, o_Fault;
  logic [31:0] o_Q;
  logic [4:0]  o_Tag;

  always #5 clk = ~clk;

  load_extend_pipe #(.p_DataWidth(32), .p_TagWidth(5)) dut (
    .i_CLK(clk), .i_RST(i_RST), .i_Flush(i_Flush), .i_Valid(i_Valid),
    .o_Ready(o_Ready), .i_D(i_D), .i_Offset(i_Offset), .i_Size(i_Size),
    .i_Unsigned(i_Unsigned), .i_Tag(i_Tag), .o_Valid(o_Valid),
    .i_Ready(i_Ready), .o_Q(o_Q), .o_Tag(o_Tag), .o_Fault(o_Fault)
  );

  typedef struct {
    logic [31:0] q;
    logic [4:0]  tag;
    logic        f;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference formatter written straight from the lane/extension rules.
  function automatic void model(input logic [31:0] d, input logic [1:0] off,
                                input logic [1:0] sz, input logic u,
                                output logic [31:0] q, output logic f);
    int w, nb, o;
    logic [31:0] sh, mask;
    w = 8 << sz;
    nb = w / 8;
    f = 1'b0;
    q = '0;
    if (w > 32) begin
`ifdef LOAD_EXTEND_FAULT_EN
      f = 1'b1;
`else
      q = d;
`endif
      return;
    end
    o = int'(off);
    if (o % nb != 0) begin
`ifdef LOAD_EXTEND_FAULT_EN
      f = 1'b1;
      return;
`else
      o = o - (o % nb);
`endif
    end
    sh = d >> (o * 8);
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    q = sh & mask;
    if (!u && sh[w-1]) q = q | ~mask;
  endfunction

  // One clock: drive, settle, score both handshakes, then advance.
  task automatic step(input logic v, input logic [31:0] d, input logic [1:0] off,
                      input logic [1:0] sz, input logic u, input logic [4:0] tag,
                      input logic rdy, input logic fl, input logic rst);
    exp_t e;
    i_Valid = v; i_D = d; i_Offset = off; i_Size = sz; i_Unsigned = u;
    i_Tag = tag; i_Ready = rdy; i_Flush = fl; i_RST = rst;
    #1;
    if (rst) chk("ready_in_reset", o_Ready, 1);
    if (!rst && o_Valid && i_Ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        $display("beat out: tag=%0d q=0x%08h fault=%0b", o_Tag, o_Q, o_Fault);
        chk("out_q", o_Q, e.q);
        chk("out_tag", o_Tag, e.tag);
        chk("out_fault", o_Fault, e.f);
      end
    end
    if (!rst && !fl && v && o_Ready) begin
      model(d, off, sz, u, e.q, e.f);
      e.tag = tag;
      sb.push_back(e);
    end
    if (rst || fl) sb.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 5'd0, rdy, 1'b0, 1'b0);
  endtask

  task automatic beat(input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz,
                      input logic u, input logic [4:0] tag, input logic rdy);
    step(1'b1, d, off, sz, u, tag, rdy, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_values();
    chk("rst_valid", o_Valid, 0);
    chk("rst_q", o_Q, 0);
    chk("rst_tag", o_Tag, 0);
    chk("rst_fault", o_Fault, 0);
    chk("rst_ready", o_Ready, 1);
  endtask

  initial begin
    logic [4:0] t;
    i_RST = 1'b1; i_Flush = 1'b0; i_Valid = 1'b0; i_D = '0; i_Offset = '0;
    i_Size = '0; i_Unsigned = 1'b0; i_Tag = '0; i_Ready = 1'b0;
    @(negedge clk);
    step(1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk_reset_values();

    // LB signed: one-cycle latency and value.
    beat(32'h80FF_7F01, 2'd3, 2'd0, 1'b0, 5'd1, 1'b1);
    chk("lb_valid", o_Valid, 1);
    chk("lb_q", o_Q, 32'hFFFF_FF80);
    chk("lb_fault", o_Fault, 0);
    idle(1'b1);

    // LHU and LH on the same word.
    beat(32'h8001_1234, 2'd2, 2'd1, 1'b1, 5'd2, 1'b1);
    chk("lhu_q", o_Q, 32'h0000_8001);
    beat(32'h8001_1234, 2'd2, 2'd1, 1'b0, 5'd3, 1'b1);
    chk("lh_q", o_Q, 32'hFFFF_8001);
    idle(1'b1);

    // Misaligned word and illegal double.
    beat(32'h1122_3344, 2'd1, 2'd2, 1'b0, 5'd4, 1'b1);
`ifdef LOAD_EXTEND_FAULT_EN
    chk("misalign_fault", o_Fault, 1);
    chk("misalign_q", o_Q, 0);
`else
    chk("misalign_fault", o_Fault, 0);
    chk("misalign_q", o_Q, 32'h1122_3344);
`endif
    beat(32'hCAFE_F00D, 2'd0, 2'd3, 1'b0, 5'd5, 1'b1);
`ifdef LOAD_EXTEND_FAULT_EN
    chk("illegal_fault", o_Fault, 1);
`else
    chk("illegal_q", o_Q, 32'hCAFE_F00D);
`endif
    chk("illegal_tag", o_Tag, 5);
    idle(1'b1);

    // Back-pressure: tags 1..4 with i_Ready low, then released.
    beat(32'h0000_0011, 2'd0, 2'd0, 1'b1, 5'd1, 1'b0);
    beat(32'h0000_2200, 2'd1, 2'd0, 1'b1, 5'd2, 1'b0);
    chk("bp_ready", o_Ready, 0);
    chk("bp_valid", o_Valid, 1);
    chk("bp_tag", o_Tag, 1);
    beat(32'h0033_0000, 2'd2, 2'd0, 1'b1, 5'd3, 1'b0);
    chk("bp_hold_tag", o_Tag, 1);
    chk("bp_hold_q", o_Q, 32'h11);
    t = 5'd3;
    for (int i = 0; i < 20 && t <= 5'd4; i++) begin
      logic acc;
      acc = o_Ready;
      beat(32'h4400_0000 >> ((4 - int'(t)) * 8), 2'(t - 5'd1), 2'd0, 1'b1, t, 1'b1);
      if (acc) t = t + 5'd1;
    end
    chk("bp_all_accepted", t, 5);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("bp_drained", sb.size(), 0);

    // Random stream through the scoreboard.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Flush from FULL with a beat offered in the flush cycle.
    beat(32'h0000_00AA, 2'd0, 2'd0, 1'b1, 5'd7, 1'b0);
    beat(32'h0000_00BB, 2'd0, 2'd0, 1'b1, 5'd8, 1'b0);
    chk("full_before_flush", o_Ready, 0);
    step(1'b1, 32'h0000_00CC, 2'd0, 2'd0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", o_Valid, 0);
    chk("flush_ready", o_Ready, 1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk("flush_absent", o_Valid, 0);
    end

    // Reset from FULL.
    beat(32'h0000_00DD, 2'd0, 2'd0, 1'b1, 5'd10, 1'b0);
    beat(32'h0000_00EE, 2'd0, 2'd0, 1'b1, 5'd11, 1'b0);
    step(1'b1, 32'h0000_00FF, 2'd0, 2'd0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b1);
    chk_reset_values();
    for (int i = 0; i < 2; i++) begin
      idle(1'b1);
      chk("reset_absent", o_Valid, 0);
    end

    // Post-reset sanity beat.
    beat(32'h0000_7F00, 2'd1, 2'd0, 1'b0, 5'd13, 1'b1);
    chk("post_rst_q", o_Q, 32'h0000_007F);
    idle(1'b1);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
